// File: rtl/k_gauss3x3_stage.sv
// 3x3 Gaussian filter stage (weights 1-2-1 / 2-4-2 / 1-2-1, normalised by 16).
// Consumes a raster-ordered pixel stream, keeps two line buffers and a 3x3 window,
// and emits one rounded, filtered pixel per interior position together with the
// window's centre coordinates.
module k_gauss3x3_stage #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_WIDTH  = 240,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned COL_W      = 8,
    parameter int unsigned ROW_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pix_valid_i,
    input  logic [DATA_W-1:0] pix_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [COL_W-1:0]  out_col_o,
    output logic [ROW_W-1:0]  out_row_o,
    output logic              frame_done_o
);

    localparam int unsigned AddrW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RsumW = DATA_W + 2;
    localparam int unsigned SumW  = DATA_W + 4;

    localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] ColTwo  = COL_W'(2);
    localparam logic [ROW_W-1:0] RowTwo  = ROW_W'(2);

    // Raster position counters
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Coordinate of the pixel presented this cycle; start forces it to (0,0)
    logic [COL_W-1:0] acc_col;
    logic [ROW_W-1:0] acc_row;
    logic             col_last;
    logic             row_last;

    // Line buffers: lb1 = previous row, lb2 = row before that (not reset)
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_q [IMG_WIDTH];
    logic [AddrW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;

    // Window: win_q[row][k], row 0 = top, k 0 = leftmost column
    logic [DATA_W-1:0] win_q [3][3];

    // Window-stage tag: set on the accept that completes an interior window
    logic              win_vld_d;
    logic              win_last_d;
    logic              win_vld_q;
    logic              win_last_q;
    logic [COL_W-1:0]  win_col_q;
    logic [ROW_W-1:0]  win_row_q;

    // Stage 1: per-row horizontal sums
    logic [RsumW-1:0]  rsum_d [3];
    logic [RsumW-1:0]  rsum_q [3];
    logic              s1_vld_q;
    logic              s1_last_q;
    logic [COL_W-1:0]  s1_col_q;
    logic [ROW_W-1:0]  s1_row_q;

    // Stage 2: vertical sum with rounding
    logic [SumW-1:0]   sum_rnd;

    // Pixel coordinate and wrap detection for the current beat
    always_comb begin
        acc_col  = start_i ? '0 : col_q;
        acc_row  = start_i ? '0 : row_q;
        col_last = (acc_col == ColLast);
        row_last = (acc_row == RowLast);
        lb_addr  = acc_col[AddrW-1:0];
        lb1_rd   = lb1_q[lb_addr];
        lb2_rd   = lb2_q[lb_addr];
    end

    // Next raster position: column fastest, row on column wrap, both wrap at frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_i) begin
            col_d = '0;
            row_d = '0;
        end
        if (pix_valid_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : acc_row + ROW_W'(1);
            end else begin
                col_d = acc_col + COL_W'(1);
                row_d = acc_row;
            end
        end
    end

    // Window validity: first two rows and first two columns never produce output
    always_comb begin
        win_vld_d  = pix_valid_i && (acc_row >= RowTwo) && (acc_col >= ColTwo);
        win_last_d = win_vld_d && col_last && row_last;
    end

    // Row sums a + 2b + c for each window row
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rsum_d[r] = '0;
            rsum_d[r] = {2'b00, win_q[r][0]}
                      + {1'b0, win_q[r][1], 1'b0}
                      + {2'b00, win_q[r][2]};
        end
    end

    // Vertical sum r0 + 2*r1 + r2 plus half an LSB of the /16 for rounding
    always_comb begin
        sum_rnd = {2'b00, rsum_q[0]}
                + {1'b0, rsum_q[1], 1'b0}
                + {2'b00, rsum_q[2]}
                + SumW'(8);
    end

    // Raster position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffer update, read-before-write at the current column
    always_ff @(posedge clk) begin
        if (pix_valid_i) begin
            lb2_q[lb_addr] <= lb1_rd;
            lb1_q[lb_addr] <= pix_data_i;
        end
    end

    // Window shift-left and load of the new column, only on accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win_q[r][k] <= '0;
                end
            end
        end else if (pix_valid_i) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= pix_data_i;
        end
    end

    // Window-stage tag; cleared on idle beats so a held window is not re-emitted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            win_col_q  <= '0;
            win_row_q  <= '0;
        end else begin
            win_vld_q  <= win_vld_d;
            win_last_q <= win_last_d;
            if (win_vld_d) begin
                win_col_q <= acc_col - COL_W'(1);
                win_row_q <= acc_row - ROW_W'(1);
            end
        end
    end

    // Stage 1: register row sums and carry the centre coordinate along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                rsum_q[r] <= '0;
            end
        end else begin
            s1_vld_q  <= win_vld_q && !start_i;
            s1_last_q <= win_last_q && !start_i;
            if (win_vld_q) begin
                s1_col_q <= win_col_q;
                s1_row_q <= win_row_q;
                for (int r = 0; r < 3; r++) begin
                    rsum_q[r] <= rsum_d[r];
                end
            end
        end
    end

    // Stage 2: normalised output; start discards anything still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            out_data_o   <= '0;
            out_col_o    <= '0;
            out_row_o    <= '0;
        end else begin
            out_valid_o  <= s1_vld_q && !start_i;
            frame_done_o <= s1_vld_q && s1_last_q && !start_i;
            if (s1_vld_q) begin
                out_data_o <= sum_rnd[SumW-1:4];
                out_col_o  <= s1_col_q;
                out_row_o  <= s1_row_q;
            end
        end
    end

endmodule

// File: tb/tb_k_gauss3x3_stage.sv
// Self-checking bench for k_gauss3x3_stage on an 8x6 image: a frame-level
// reference model predicts every output and its cycle, plus literal pins.
module tb_k_gauss3x3_stage;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_col;
    logic [7:0]    out_row;
    logic          frame_done;

    k_gauss3x3_stage #(
        .DATA_W    (DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (8),
        .ROW_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_col_o   (out_col),
        .out_row_o   (out_row),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int d;
        int r;
        int c;
        bit fd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   mr = 0;
    int   mc = 0;
    int   img[H][W];
    int   cap[H][W];
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    int   fd_cnt = 0;
    int   fd_row = -1;
    int   fd_col = -1;
    int   first_row = -1;
    int   first_col = -1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Gaussian of the 3x3 neighbourhood centred at (r,c) of the current frame
    function automatic int gauss(input int r, input int c);
        int s;
        int wt;
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                wt = 1;
                if (dr == 0) wt = wt * 2;
                if (dc == 0) wt = wt * 2;
                s += wt * img[r + dr][c + dc];
            end
        end
        return (s + 8) / 16;
    endfunction

    // Reset drops everything the model expected
    initial begin
        forever begin
            @(posedge rst);
            q.delete();
            mr = 0;
            mc = 0;
        end
    end

    // Model update on each edge, then compare and capture 1 time unit later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                if (start) begin
                    q.delete();
                    mr = 0;
                    mc = 0;
                end
                if (pix_valid) begin
                    img[mr][mc] = int'(pix_data);
                    if (mr >= 2 && mc >= 2) begin
                        e.due = cyc + 2;
                        e.d   = gauss(mr - 1, mc - 1);
                        e.r   = mr - 1;
                        e.c   = mc - 1;
                        e.fd  = (mr == H - 1) && (mc == W - 1);
                        q.push_back(e);
                    end
                    mc++;
                    if (mc == W) begin
                        mc = 0;
                        mr++;
                        if (mr == H) mr = 0;
                    end
                end
            end
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("out_valid", int'(out_valid), 1);
                chk("out_data", int'(out_data), e.d);
                chk("out_row", int'(out_row), e.r);
                chk("out_col", int'(out_col), e.c);
                chk("frame_done", int'(frame_done), int'(e.fd));
            end else begin
                chk("idle_out_valid", int'(out_valid), 0);
                chk("idle_frame_done", int'(frame_done), 0);
            end
            if (out_valid === 1'b1) begin
                if (out_cnt == 0) begin
                    first_row = int'(out_row);
                    first_col = int'(out_col);
                end
                out_cnt++;
                if (int'(out_row) < H && int'(out_col) < W) cap[out_row][out_col] = int'(out_data);
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    fd_row = int'(out_row);
                    fd_col = int'(out_col);
                end
            end
        end
    end

    task automatic clear_stats();
        out_cnt   = 0;
        fd_cnt    = 0;
        fd_row    = -1;
        fd_col    = -1;
        first_row = -1;
        first_col = -1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cap[r][c] = -1;
            end
        end
    endtask

    // mode 0: constant val, 1: impulse 160 at (3,3), 2: random
    task automatic send(input int mode, input int val, input int gapmax,
                        input bit with_start, input int npix);
        int r;
        int c;
        int g;
        for (int p = 0; p < npix; p++) begin
            r = (p / W) % H;
            c = p % W;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                @(negedge clk);
                pix_valid = 1'b0;
                start     = 1'b0;
            end
            @(negedge clk);
            pix_valid = 1'b1;
            start     = with_start && (p == 0);
            case (mode)
                0:       pix_data = DW'(val);
                1:       pix_data = (r == 3 && c == 3) ? 8'd160 : 8'd0;
                default: pix_data = DW'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            start     = 1'b0;
        end
    endtask

    task automatic check_impulse(input string tag);
        chk({tag, "_cnt"}, out_cnt, 24);
        chk({tag, "_c33"}, cap[3][3], 40);
        chk({tag, "_c23"}, cap[2][3], 20);
        chk({tag, "_c43"}, cap[4][3], 20);
        chk({tag, "_c32"}, cap[3][2], 20);
        chk({tag, "_c34"}, cap[3][4], 20);
        chk({tag, "_c22"}, cap[2][2], 10);
        chk({tag, "_c44"}, cap[4][4], 10);
        chk({tag, "_c24"}, cap[2][4], 10);
        chk({tag, "_c42"}, cap[4][2], 10);
        chk({tag, "_c11"}, cap[1][1], 0);
        chk({tag, "_c46"}, cap[4][6], 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_col", int'(out_col), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // Constant 100, continuous
        clear_stats();
        send(0, 100, 0, 1'b1, W * H);
        idle(4);
        chk("const_cnt", out_cnt, 24);
        chk("const_fd_cnt", fd_cnt, 1);
        chk("const_fd_row", fd_row, 4);
        chk("const_fd_col", fd_col, 6);
        chk("const_first_row", first_row, 1);
        chk("const_first_col", first_col, 1);
        chk("const_c11", cap[1][1], 100);
        chk("const_c46", cap[4][6], 100);

        // Impulse, continuous
        clear_stats();
        send(1, 0, 0, 1'b0, W * H);
        idle(4);
        check_impulse("imp");

        // Maximum value
        clear_stats();
        send(0, 255, 0, 1'b0, W * H);
        idle(4);
        chk("max_cnt", out_cnt, 24);
        chk("max_c23", cap[2][3], 255);
        chk("max_c46", cap[4][6], 255);

        // Impulse with random input gaps
        clear_stats();
        send(1, 0, 2, 1'b0, W * H);
        idle(4);
        check_impulse("gap");
        chk("gap_fd_cnt", fd_cnt, 1);

        // Three random frames back to back with gaps
        clear_stats();
        send(2, 0, 1, 1'b0, W * H * 3);
        idle(4);
        chk("rand_cnt", out_cnt, 72);
        chk("rand_fd_cnt", fd_cnt, 3);

        // Abort after 20 pixels, restart with start
        clear_stats();
        send(0, 77, 0, 1'b0, 20);
        send(0, 50, 0, 1'b1, W * H);
        idle(4);
        chk("abort_cnt", out_cnt, 24);
        chk("abort_fd_cnt", fd_cnt, 1);
        chk("abort_c11", cap[1][1], 50);
        chk("abort_c46", cap[4][6], 50);
        chk("abort_first_row", first_row, 1);
        chk("abort_first_col", first_col, 1);

        // Async reset between edges during row 3
        clear_stats();
        send(0, 100, 0, 1'b0, 28);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_col", int'(out_col), 0);
        chk("arst_out_row", int'(out_row), 0);
        chk("arst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        clear_stats();
        send(0, 50, 0, 1'b0, W * H);
        idle(4);
        chk("post_rst_cnt", out_cnt, 24);
        chk("post_rst_fd_cnt", fd_cnt, 1);
        chk("post_rst_first_row", first_row, 1);
        chk("post_rst_first_col", first_col, 1);
        chk("post_rst_c33", cap[3][3], 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
